fir_filter_serial_mc: RTL and testbench

//   Time-multiplexed single-MAC FIR filter, successor to the fixed 128-tap serial FIR.

---
 rtl/fir_filter_serial_mc.sv | 175 +++++++++++++++++
 tb/tb_fir_filter_serial_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_serial_mc.sv
// Multi-channel serial FIR: one shared MAC and one runtime-writable coefficient bank.
// Each accepted sample yields one rounded, saturated result tagged with its channel.
module fir_filter_serial_mc #(
    parameter int WIDTH  = 18,
    parameter int COEF_W = 18,
    parameter int NTAPS  = 128,
    parameter int NCH    = 2,
    parameter int SHIFT  = 8,
    parameter int ACC_W  = WIDTH + COEF_W + $clog2(NTAPS),
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int TAP_W = $clog2(NTAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  in_data,
    input  logic [CH_W-1:0]          in_ch,
    input  logic                     coef_we,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     coef_err,
    output logic                     out_valid,
    output logic signed [WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]          out_ch
);

    localparam int DEPTH  = NCH * NTAPS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PROD_W = WIDTH + COEF_W;
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W + 1)'(-(2 ** (WIDTH - 1)));

    typedef enum logic [1:0] {S_CLR, S_IDLE, S_MAC, S_DRAIN} state_t;

    state_t                    state_q;
    logic [ADDR_W-1:0]         clr_cnt_q;
    logic [TAP_W-1:0]          wptr_q [NCH];
    logic [CH_W-1:0]           ch_q;
    logic [TAP_W-1:0]          rd_q;
    logic [TAP_W-1:0]          tap_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [COEF_W-1:0]  coef_q [NTAPS];
    logic signed [WIDTH-1:0]   dl_q [DEPTH];
    logic                      coef_err_q;
    logic                      out_valid_q;
    logic signed [WIDTH-1:0]   out_data_q;
    logic [CH_W-1:0]           out_ch_q;

    logic                      ch_ok;
    logic [CH_W-1:0]           ch_sel;
    logic                      dl_we;
    logic [ADDR_W-1:0]         dl_wa;
    logic signed [WIDTH-1:0]   dl_wd;
    logic signed [WIDTH-1:0]   x_rd;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   acc_sum_d;
    logic signed [ACC_W:0]     rnd_d;
    logic signed [ACC_W:0]     sh_d;
    logic signed [WIDTH-1:0]   sat_d;

    function automatic logic [ADDR_W-1:0] dl_addr(input logic [CH_W-1:0] ch,
                                                  input logic [TAP_W-1:0] idx);
        return ADDR_W'(int'(ch) * NTAPS + int'(idx));
    endfunction

    // Input handshake: a sample is consumed at a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, so a source seeing in_ready low must hold its sample.
    assign in_ready  = (state_q == S_IDLE);
    assign coef_err  = coef_err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    if ((1 << CH_W) > NCH) begin : g_ch_chk
        assign ch_ok = (in_ch < CH_W'(NCH));
    end else begin : g_ch_all
        assign ch_ok = 1'b1;
    end
    assign ch_sel = ch_ok ? in_ch : '0;

    always_comb begin
        dl_we = 1'b0;
        dl_wa = '0;
        dl_wd = '0;
        if (!rst) begin
            if (state_q == S_CLR) begin
                dl_we = 1'b1;
                dl_wa = clr_cnt_q;
            end else if (state_q == S_IDLE && in_valid && ch_ok) begin
                dl_we = 1'b1;
                dl_wa = dl_addr(ch_sel, wptr_q[ch_sel]);
                dl_wd = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dl_we) dl_q[dl_wa] <= dl_wd;
    end

    // rd_q walks backwards from the newest sample, so tap k sees the k-th most recent one.
    assign x_rd      = dl_q[dl_addr(ch_q, rd_q)];
    assign prod_d    = coef_q[tap_q] * x_rd;
    assign acc_sum_d = acc_q + {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};
    assign rnd_d     = {acc_sum_d[ACC_W-1], acc_sum_d} + HALF;
    assign sh_d      = rnd_d >>> SHIFT;

    always_comb begin
        sat_d = sh_d[WIDTH-1:0];
        if (sh_d > MAXV)      sat_d = {1'b0, {(WIDTH - 1){1'b1}}};
        else if (sh_d < MINV) sat_d = {1'b1, {(WIDTH - 1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_CLR;
            clr_cnt_q   <= '0;
            ch_q        <= '0;
            rd_q        <= '0;
            tap_q       <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            coef_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            for (int c = 0; c < NCH; c++) wptr_q[c] <= '0;
            for (int k = 0; k < NTAPS; k++)
                coef_q[k] <= (k == 0) ? COEF_W'(1 << SHIFT) : '0;
        end else begin
            out_valid_q <= 1'b0;
            if (coef_we) begin
                if (state_q == S_IDLE) coef_q[coef_addr] <= coef_data;
                else                   coef_err_q <= 1'b1;
            end
            case (state_q)
                S_CLR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (in_valid && ch_ok) begin
                        wptr_q[ch_sel] <= (wptr_q[ch_sel] == TAP_W'(NTAPS - 1)) ?
                                          '0 : wptr_q[ch_sel] + 1'b1;
                        ch_q    <= ch_sel;
                        rd_q    <= wptr_q[ch_sel];
                        tap_q   <= '0;
                        acc_q   <= '0;
                        prod_q  <= '0;
                        state_q <= S_MAC;
                    end
                end
                S_MAC: begin
                    prod_q <= prod_d;
                    acc_q  <= acc_sum_d;
                    rd_q   <= (rd_q == '0) ? TAP_W'(NTAPS - 1) : rd_q - 1'b1;
                    tap_q  <= tap_q + 1'b1;
                    if (tap_q == TAP_W'(NTAPS - 1)) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    acc_q       <= acc_sum_d;
                    out_data_q  <= sat_d;
                    out_ch_q    <= ch_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_serial_mc.sv
// Directed bench for fir_filter_serial_mc (16-bit, 8 taps, 2 channels, shift 8):
// vector tables for filtering/arithmetic plus hand sequences for reset and coefficient timing.
module tb_fir_filter_serial_mc;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_data = '0;
    logic               in_ch = 1'b0;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [15:0] coef_data = '0;
    logic               coef_err;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_ch;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit                 hs_we;
        logic [2:0]         ca;
        logic signed [15:0] cd;
        logic               ch;
        logic signed [15:0] din;
        logic signed [15:0] exp_d;
    } vec_t;

    vec_t imp_tv [15];
    vec_t ar_tv [8];

    fir_filter_serial_mc #(
        .WIDTH(16), .COEF_W(16), .NTAPS(8), .NCH(2), .SHIFT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_clr(input string nm);
        int n;
        bit ov;
        n = 0;
        ov = 1'b0;
        while (!in_ready && n < 200) begin
            if (out_valid) ov = 1'b1;
            @(negedge clk);
            n++;
        end
        chk({nm, "_clr_len"}, n, 16);
        chk({nm, "_no_out_valid"}, ov, 0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        coef_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_clr(nm);
    endtask

    task automatic write_coef(input logic [2:0] ca, input logic signed [15:0] cd);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        coef_we = 1'b1;
        coef_addr = ca;
        coef_data = cd;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Offers one sample; optionally writes a coefficient on the handshake edge (hs_we)
    // or two cycles later while the MAC is running (mac_we). Returns result and latency.
    task automatic send(input logic ch, input logic signed [15:0] d, input bit hs_we,
                        input bit mac_we, input logic [2:0] ca, input logic signed [15:0] cd,
                        output logic signed [15:0] od, output logic och, output int lat);
        int n;
        n = 0;
        od = '0;
        och = 1'b0;
        lat = -1;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("send_ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_ch = ch;
        in_data = d;
        coef_we = hs_we;
        coef_addr = ca;
        coef_data = cd;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            coef_we = mac_we && (j == 2);
            if (out_valid) begin
                lat = j;
                od = out_data;
                och = out_ch;
                break;
            end
            @(negedge clk);
        end
        coef_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic signed [15:0] od;
        logic och;
        int lat;
        send(v.ch, v.din, v.hs_we, 1'b0, v.ca, v.cd, od, och, lat);
        chk({nm, "_data"}, od, v.exp_d);
        chk({nm, "_ch"}, och, v.ch);
        chk({nm, "_latency"}, lat, 10);
        @(negedge clk);
        chk({nm, "_pulse_width"}, out_valid, 0);
    endtask

    initial begin
        logic signed [15:0] od;
        logic och;
        int lat;
        bit ov;

        for (int i = 0; i < 8; i++) begin
            imp_tv[2 * i] = '{1'b0, 3'd0, 16'sd0, 1'b1, (i == 0) ? 16'sd1 : 16'sd0, 16'(i + 1)};
            if (i < 7) imp_tv[2 * i + 1] = '{1'b0, 3'd0, 16'sd0, 1'b0, 16'sd0, 16'sd0};
        end
        ar_tv[0] = '{1'b1, 3'd0, 16'sd128,    1'b0, 16'sd3,      16'sd2};
        ar_tv[1] = '{1'b1, 3'd0, 16'sd128,    1'b0, -16'sd3,     -16'sd1};
        ar_tv[2] = '{1'b1, 3'd0, 16'sd128,    1'b1, 16'sd1,      16'sd1};
        ar_tv[3] = '{1'b1, 3'd0, 16'sd128,    1'b1, -16'sd1,     16'sd0};
        ar_tv[4] = '{1'b1, 3'd0, 16'sd32767,  1'b0, 16'sd32767,  16'sd32767};
        ar_tv[5] = '{1'b1, 3'd0, 16'sd32767,  1'b0, -16'sd32768, -16'sd32768};
        ar_tv[6] = '{1'b1, 3'd0, -16'sd32768, 1'b1, -16'sd32768, 16'sd32767};
        ar_tv[7] = '{1'b1, 3'd0, 16'sd256,    1'b0, -16'sd5,     -16'sd5};

        // Power-on reset state and clear sequence.
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_coef_err", coef_err, 0);
        rst = 1'b0;
        wait_clr("por");

        // Passthrough latency with default coefficients.
        send(1'b0, 16'sd100, 1'b0, 1'b0, 3'd0, 16'sd0, od, och, lat);
        chk("pass_latency", lat, 10);
        chk("pass_data", od, 100);
        chk("pass_ch", och, 0);
        @(negedge clk);
        chk("pass_pulse_width", out_valid, 0);
        chk("pass_data_hold", out_data, 100);

        // Ramp coefficients, impulse on ch1 interleaved with ch0 zeros.
        do_reset("rst2");
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'((k + 1) * 256));
        chk("ramp_coef_err", coef_err, 0);
        for (int i = 0; i < 15; i++) run_vec(imp_tv[i], $sformatf("imp%0d", i));

        // Coefficient write during MAC is dropped and flagged.
        send(1'b0, 16'sd1, 1'b0, 1'b1, 3'd0, 16'sd32767, od, och, lat);
        chk("macwe_data", od, 1);
        chk("macwe_coef_err", coef_err, 1);
        send(1'b0, 16'sd2, 1'b0, 1'b0, 3'd0, 16'sd0, od, och, lat);
        chk("macwe_coef_kept", od, 4);
        // Write on the handshake edge is used by that same sample.
        send(1'b0, 16'sd4, 1'b1, 1'b0, 3'd0, 16'sd1024, od, och, lat);
        chk("hswe_data", od, 23);
        chk("hswe_coef_err_sticky", coef_err, 1);

        // Single-tap arithmetic: rounding and saturation.
        for (int k = 1; k < 8; k++) write_coef(3'(k), 16'sd0);
        for (int i = 0; i < 8; i++) run_vec(ar_tv[i], $sformatf("arith%0d", i));

        // Reset in the middle of a MAC.
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_ch = 1'b0;
        in_data = 16'sd50;
        @(negedge clk);
        in_valid = 1'b0;
        ov = 1'b0;
        repeat (3) begin
            if (out_valid) ov = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        if (out_valid) ov = 1'b1;
        rst = 1'b0;
        chk("midrst_out_data", out_data, 0);
        chk("midrst_coef_err", coef_err, 0);
        wait_clr("midrst");
        chk("midrst_no_pulse_before", ov, 0);
        send(1'b1, 16'sd123, 1'b0, 1'b0, 3'd0, 16'sd0, od, och, lat);
        chk("midrst_passthrough", od, 123);
        chk("midrst_passthrough_ch", och, 1);
        for (int k = 0; k < 8; k++) write_coef(3'(k), 16'sd256);
        send(1'b0, 16'sd0, 1'b0, 1'b0, 3'd0, 16'sd0, od, och, lat);
        chk("midrst_ch0_cleared", od, 0);
        send(1'b1, 16'sd0, 1'b0, 1'b0, 3'd0, 16'sd0, od, och, lat);
        chk("midrst_ch1_history", od, 123);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
